// File: rtl/hs_receiver_if.sv
// ---------------------------------------------------------------------------
// hs_receiver_if
//
// Purpose: bundles the sender-side handshake (synchronized request, data word,
// acknowledge), the local consumer's valid/ready port and the timeout error
// flag/clear of the handshake receiver.
//
// Signals:
//   req_sync    request from the sender, already synchronized to clk
//   data_in     sender data word, held by the sender while its req is high
//   ack         acknowledge back toward the sender domain
//   out_valid   out_data holds an unconsumed word
//   out_data    captured word
//   out_ready   local consumer accepts the word
//   timeout_err sticky flag: sender kept req high too long after ack
//   err_clr     clears timeout_err
//
// Modports:
//   slave  - the receiver itself
//   master - the environment (sender + consumer + error handler)
// ---------------------------------------------------------------------------
interface hs_receiver_if #(
  parameter int DW = 32
);
  logic          req_sync;
  logic [DW-1:0] data_in;
  logic          ack;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          timeout_err;
  logic          err_clr;

  modport slave (
    input  req_sync, data_in, out_ready, err_clr,
    output ack, out_valid, out_data, timeout_err
  );

  modport master (
    output req_sync, data_in, out_ready, err_clr,
    input  ack, out_valid, out_data, timeout_err
  );
endinterface

// File: rtl/hs_receiver.sv
// ---------------------------------------------------------------------------
// hs_receiver
//
// Purpose: receive side of a four-phase req/ack handshake. A word presented
// by the sender is captured when the synchronized request is seen high,
// offered to a local consumer with valid/ready, and acknowledged back to the
// sender once the consumer takes it. The acknowledge is held until the
// sender drops its request. A saturating counter watches how long the sender
// keeps req high while acknowledged and raises a sticky timeout flag.
//
// Parameters:
//   DW       data word width
//   TIMEOUT  cycles req_sync may stay high while acknowledged (2..65535)
//
// Ports:
//   clk    block clock
//   reset  asynchronous, active-high reset
//   bus    hs_receiver_if.slave (req_sync, data_in, ack, out_valid,
//          out_data, out_ready, timeout_err, err_clr)
// ---------------------------------------------------------------------------
module hs_receiver #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           reset,
  hs_receiver_if.slave   bus
);

  localparam int             CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t        state;
  logic          ack_r;
  logic          valid_r;
  logic [DW-1:0] data_r;
  logic          err_r;
  logic [CW-1:0] cnt;
  logic          to_hit;

  // Counter stops at the limit so the equality compare keeps firing for as
  // long as the sender holds req high; a clear cannot hide a stuck sender.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  assign to_hit = (state == ACK) && bus.req_sync && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ack_r   <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= '0;
      err_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_sync) begin
            data_r  <= bus.data_in;
            valid_r <= 1'b1;
            state   <= VALID;
          end
        end
        // A req drop here violates the protocol; the word has already been
        // captured, so it is still delivered and acknowledged.
        VALID: begin
          if (bus.out_ready) begin
            valid_r <= 1'b0;
            ack_r   <= 1'b1;
            cnt     <= '0;
            state   <= ACK;
          end
        end
        ACK: begin
          if (!bus.req_sync) begin
            ack_r <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          ack_r   <= 1'b0;
          valid_r <= 1'b0;
          state   <= IDLE;
        end
      endcase

      // Sticky error; a set in the same cycle as a clear takes priority.
      if (to_hit) begin
        err_r <= 1'b1;
      end else if (bus.err_clr) begin
        err_r <= 1'b0;
      end
    end
  end

  assign bus.ack         = ack_r;
  assign bus.out_valid   = valid_r;
  assign bus.out_data    = data_r;
  assign bus.timeout_err = err_r;

endmodule

// File: tb/tb_hs_receiver.sv
module tb_hs_receiver;

  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hs_receiver_if #(.DW(DW)) bus ();

  hs_receiver #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic outs(input string tag, input logic v, input logic a, input logic e);
    check({tag, "_valid"}, bus.out_valid, v);
    check({tag, "_ack"}, bus.ack, a);
    check({tag, "_err"}, bus.timeout_err, e);
  endtask

  // Reference model: transaction flags plus an unbounded count of
  // acknowledged cycles with req still high.
  bit          m_hold;
  bit          m_acked;
  bit          m_err;
  int          m_hi;
  logic [31:0] m_data;

  task automatic model_step();
    bit set_err;
    set_err = 1'b0;
    if (m_acked) begin
      if (!bus.req_sync) m_acked = 1'b0;
      else begin
        if (m_hi >= TO - 1) set_err = 1'b1;
        m_hi++;
      end
    end else if (m_hold) begin
      if (bus.out_ready) begin
        m_hold  = 1'b0;
        m_acked = 1'b1;
        m_hi    = 0;
      end
    end else if (bus.req_sync) begin
      m_hold = 1'b1;
      m_data = bus.data_in;
    end
    if (set_err) m_err = 1'b1;
    else if (bus.err_clr) m_err = 1'b0;
  endtask

  logic [31:0] offered[$];
  logic [31:0] exp_w;
  int          d_st;
  int          d_delay;
  bit          saw_ack;

  initial begin
    reset         = 1'b1;
    bus.req_sync  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    #1;
    outs("reset", 1'b0, 1'b0, 1'b0);
    check("reset_data", bus.out_data, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Basic transfer
    bus.req_sync = 1'b1; bus.data_in = 32'hDEADBEEF; bus.out_ready = 1'b1;
    cyc(1);
    outs("basic_cap", 1'b1, 1'b0, 1'b0);
    check("basic_data", bus.out_data, 32'hDEADBEEF);
    cyc(1);
    outs("basic_acc", 1'b0, 1'b1, 1'b0);
    cyc(2);
    check("basic_hold_ack", bus.ack, 1'b1);
    bus.req_sync = 1'b0;
    cyc(1);
    outs("basic_rel", 1'b0, 1'b0, 1'b0);

    // Backpressure, with data_in wandering to show the capture is frozen
    bus.out_ready = 1'b0; bus.req_sync = 1'b1; bus.data_in = 32'h12345678;
    cyc(1);
    for (int i = 0; i < 20; i++) begin
      bus.data_in = $urandom;
      cyc(1);
      outs("bp", 1'b1, 1'b0, 1'b0);
      check("bp_data", bus.out_data, 32'h12345678);
    end
    bus.out_ready = 1'b1;
    cyc(1);
    outs("bp_acc", 1'b0, 1'b1, 1'b0);
    bus.req_sync = 1'b0;
    cyc(1);
    outs("bp_rel", 1'b0, 1'b0, 1'b0);

    // Timeout: ACK entered at one edge, flag after the eighth further edge
    bus.req_sync = 1'b1; bus.data_in = 32'hA5A5A5A5;
    cyc(2);
    outs("to_enter", 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < TO; i++) begin
      cyc(1);
      check("to_early_err", bus.timeout_err, 1'b0);
    end
    cyc(1);
    outs("to_set", 1'b0, 1'b1, 1'b1);
    bus.req_sync = 1'b0;
    cyc(1);
    outs("to_idle", 1'b0, 1'b0, 1'b1);
    cyc(1);
    check("to_sticky", bus.timeout_err, 1'b1);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    check("to_clr", bus.timeout_err, 1'b0);

    // Clear in the same cycle the limit is hit: set wins
    bus.req_sync = 1'b1;
    cyc(2);
    check("to2_ack", bus.ack, 1'b1);
    cyc(TO - 1);
    check("to2_pre", bus.timeout_err, 1'b0);
    bus.err_clr = 1'b1;
    cyc(1);
    check("to2_setwins", bus.timeout_err, 1'b1);
    cyc(1);
    check("to2_saturated", bus.timeout_err, 1'b1);
    bus.err_clr = 1'b0; bus.req_sync = 1'b0;
    cyc(1);
    outs("to2_idle", 1'b0, 1'b0, 1'b1);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    check("to2_clr", bus.timeout_err, 1'b0);

    // Reset while VALID
    bus.out_ready = 1'b0; bus.req_sync = 1'b1; bus.data_in = 32'hCAFEF00D;
    cyc(1);
    check("rv_valid", bus.out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    outs("rv_async", 1'b0, 1'b0, 1'b0);
    check("rv_data", bus.out_data, 0);
    bus.req_sync = 1'b0;
    cyc(1);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    cyc(3);
    outs("rv_idle", 1'b0, 1'b0, 1'b0);

    // Reset while ACK with the error flag up
    bus.req_sync = 1'b1; bus.data_in = 32'h55AA55AA;
    cyc(TO + 2);
    outs("ra_pre", 1'b0, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    outs("ra_async", 1'b0, 1'b0, 1'b0);
    check("ra_data", bus.out_data, 0);
    bus.req_sync = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    outs("ra_idle", 1'b0, 1'b0, 1'b0);

    // Protocol violation: req drops while the word waits
    bus.out_ready = 1'b0; bus.req_sync = 1'b1; bus.data_in = 32'h0BADF00D;
    cyc(1);
    check("pv_valid", bus.out_valid, 1'b1);
    bus.req_sync = 1'b0;
    cyc(2);
    outs("pv_wait", 1'b1, 1'b0, 1'b0);
    check("pv_data", bus.out_data, 32'h0BADF00D);
    bus.out_ready = 1'b1;
    cyc(1);
    outs("pv_acc", 1'b0, 1'b1, 1'b0);
    cyc(1);
    outs("pv_done", 1'b0, 1'b0, 1'b0);
    cyc(1);
    outs("pv_idle", 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the reference model
    reset = 1'b1;
    bus.req_sync = 1'b0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    cyc(1);
    reset = 1'b0;
    m_hold = 0; m_acked = 0; m_err = 0; m_hi = 0; m_data = '0;
    d_st = 0; d_delay = 0; saw_ack = 0;
    for (int c = 0; c < 4000; c++) begin
      case (d_st)
        0: begin
          bus.data_in = $urandom;
          if ($urandom_range(0, 1) == 1) begin
            bus.req_sync = 1'b1;
            offered.push_back(bus.data_in);
            saw_ack = 1'b0;
            d_delay = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
            d_st = 1;
          end
        end
        1: begin
          if (bus.ack) begin
            saw_ack = 1'b1;
            if (d_delay == 0) begin
              bus.req_sync = 1'b0;
              d_st = 2;
            end else d_delay--;
          end else if ($urandom_range(0, 29) == 0) begin
            bus.req_sync = 1'b0;
            d_st = 2;
          end
        end
        default: begin
          bus.data_in = $urandom;
          if (bus.ack) saw_ack = 1'b1;
          else if (saw_ack) d_st = 0;
        end
      endcase
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.err_clr   = ($urandom_range(0, 15) == 0);

      if (bus.out_valid && bus.out_ready) begin
        if (offered.size() == 0) check("rnd_spurious_word", bus.out_valid, 1'b0);
        else begin
          exp_w = offered.pop_front();
          check("rnd_deliver", bus.out_data, exp_w);
        end
      end

      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rnd_valid", bus.out_valid, m_hold);
      check("rnd_ack", bus.ack, m_acked);
      check("rnd_err", bus.timeout_err, m_err);
      check("rnd_data", bus.out_data, m_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
